shift_right_seq16: RTL

Sequenced 16-bit right-shift register with a serial input and a serial output. It is the counterpart of the 16-bit left-shift register in the datapath: it loads a parallel word, shifts it right a programmed number of places (1..16), and emits each LSB on a serial output. Serial-in bits come from the caller, so the same block serves logical shifts, arithmetic shifts, rotate-through-carry and multiply steps. A small state machine with a down-counter sequences the shift and reports busy/done, so the ALU controller issues one start per shift operation.

---
 rtl/shift_right_seq16_if.sv | 15 +
 rtl/shift_right_seq16.sv | 62 ++++++
 2 files changed

// File: rtl/shift_right_seq16_if.sv
// shift_right_seq16_if: control, data and status signals of the sequenced right shifter
interface shift_right_seq16_if;
    logic [15:0] d;
    logic [4:0]  cnt;
    logic        start;
    logic        we;
    logic        srin;
    logic [15:0] q;
    logic        sout;
    logic        busy;
    logic        done;

    modport master (output d, cnt, start, we, srin, input q, sout, busy, done);
    modport slave  (input d, cnt, start, we, srin, output q, sout, busy, done);
endinterface

// File: rtl/shift_right_seq16.sv
// shift_right_seq16: 16-bit right shifter sequenced by a down-counter, serial in/out, busy/done status
module shift_right_seq16 (
    input  logic               clk,
    input  logic               rst_n,
    shift_right_seq16_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nx;
    logic [15:0] q_r, q_nx;
    logic        sout_r, sout_nx;
    logic [4:0]  rem, rem_nx;
    logic [4:0]  cnt_c;

    assign cnt_c    = (bus.cnt > 5'd16) ? 5'd16 : bus.cnt;
    assign bus.q    = q_r;
    assign bus.sout = sout_r;
    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);

    // Next state: load on start or we in IDLE, shift one place per SHIFT cycle, single DONE cycle
    always_comb begin
        state_nx = state;
        q_nx     = q_r;
        sout_nx  = sout_r;
        rem_nx   = rem;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    q_nx     = bus.d;
                    sout_nx  = 1'b0;
                    rem_nx   = cnt_c;
                    state_nx = (cnt_c != 5'd0) ? SHIFT : DONE;
                end else if (bus.we) begin
                    q_nx = bus.d;
                end
            end
            SHIFT: begin
                q_nx     = {bus.srin, q_r[15:1]};
                sout_nx  = q_r[0];
                rem_nx   = rem - 5'd1;
                state_nx = (rem == 5'd1) ? DONE : SHIFT;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            q_r    <= 16'h0000;
            sout_r <= 1'b0;
            rem    <= 5'd0;
        end else begin
            state  <= state_nx;
            q_r    <= q_nx;
            sout_r <= sout_nx;
            rem    <= rem_nx;
        end
    end
endmodule
